// File: rtl/four_bit_up_counter_mod.sv
// ---------------------------------------------------------------------------
// four_bit_up_counter_mod
//
// Synchronous modulo-N up counter. It supports parallel load with clamping,
// count enable and an optional one-shot (stop-at-terminal) mode. It provides
// a terminal-count flag, a combinational cascade carry and a sticky overflow
// flag.
//
// Parameters
//   WIDTH     counter width in bits
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//   ONE_SHOT  0: wrap to 0 after MODULUS-1; 1: hold at MODULUS-1, raise done
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high reset
//   en         in   count enable
//   load       in   parallel load strobe (beats en)
//   load_val   in   value to load; values above MODULUS-1 clamp to MODULUS-1
//   ovf_clr    in   synchronous clear of the sticky ovf flag
//   Cout       out  registered count
//   tc         out  combinational, Cout == MODULUS-1
//   carry_out  out  combinational, en & tc & ~load & ~clear (next stage en)
//   ovf        out  registered sticky flag, set on every wrap
//   done       out  registered, high while held at terminal (ONE_SHOT=1 only)
// ---------------------------------------------------------------------------
module four_bit_up_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Cout,
    output logic             tc,
    output logic             carry_out,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    // Loaded values outside the count range saturate at the terminal value.
    function automatic logic [WIDTH-1:0] clamp_term(input logic [WIDTH-1:0] v);
        return (v > TERM) ? TERM : v;
    endfunction

    logic [WIDTH-1:0] cnt_p0;
    logic             ovf_p0;
    logic             done_p0;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap;

    assign load_clamped = clamp_term(load_val);

    assign tc        = (cnt_p0 == TERM);
    assign carry_out = en & tc & ~load & ~clear;
    // A wrap only exists in free-running mode; one-shot holds instead.
    assign wrap      = carry_out & ~ONE_SHOT;

    // ---- stage p0: count, sticky overflow and one-shot state ----
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_p0  <= '0;
            ovf_p0  <= 1'b0;
            done_p0 <= 1'b0;
        end else begin
            if (load) begin
                cnt_p0  <= load_clamped;
                done_p0 <= ONE_SHOT && (load_clamped == TERM);
            end else if (en) begin
                if (tc) begin
                    if (ONE_SHOT) begin
                        done_p0 <= 1'b1;
                    end else begin
                        cnt_p0 <= '0;
                    end
                end else begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end

            // A wrap on the same edge as ovf_clr leaves the flag set.
            if (wrap) begin
                ovf_p0 <= 1'b1;
            end else if (ovf_clr) begin
                ovf_p0 <= 1'b0;
            end
        end
    end

    assign Cout = cnt_p0;
    assign ovf  = ovf_p0;
    assign done = ONE_SHOT ? done_p0 : 1'b0;

endmodule

// File: tb/tb_four_bit_up_counter_mod.sv
module tb_four_bit_up_counter_mod;

    logic       clk = 1'b0;
    logic       clear, en, load, ovf_clr;
    logic [3:0] load_val;

    // cascade stimulus
    logic       cclr, cen;

    logic [3:0] c16, c10, cos, cs0, cs1;
    logic       tc16, tc10, tcos, tcs0, tcs1;
    logic       co16, co10, coos, cos0, cos1;
    logic       ov16, ov10, ovos, ovs0, ovs1;
    logic       dn16, dn10, dnos, dns0, dns1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    four_bit_up_counter_mod #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(1'b0)) u16 (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .Cout(c16), .tc(tc16), .carry_out(co16),
        .ovf(ov16), .done(dn16));

    four_bit_up_counter_mod #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) u10 (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .Cout(c10), .tc(tc10), .carry_out(co10),
        .ovf(ov10), .done(dn10));

    four_bit_up_counter_mod #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(1'b1)) uos (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .ovf_clr(ovf_clr), .Cout(cos), .tc(tcos), .carry_out(coos),
        .ovf(ovos), .done(dnos));

    // Two-stage BCD cascade
    four_bit_up_counter_mod #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) us0 (
        .clk(clk), .clear(cclr), .en(cen), .load(1'b0), .load_val(4'd0),
        .ovf_clr(1'b0), .Cout(cs0), .tc(tcs0), .carry_out(cos0),
        .ovf(ovs0), .done(dns0));

    four_bit_up_counter_mod #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1'b0)) us1 (
        .clk(clk), .clear(cclr), .en(cos0), .load(1'b0), .load_val(4'd0),
        .ovf_clr(1'b0), .Cout(cs1), .tc(tcs1), .carry_out(cos1),
        .ovf(ovs1), .done(dns1));

    typedef struct {
        int         sel;      // 0: mod16, 1: mod10, 2: one-shot mod16
        logic       clr, en, ld;
        logic [3:0] lv;
        logic       oc;
        logic       chk_comb; // compare tc/carry_out before the edge
        logic       tc, co;
        int         cout;
        logic       ovf;
        logic       chk_done;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int sel, logic clr, logic e, logic ld, int lv,
                                logic oc, logic cc, logic t, logic c, int cout,
                                logic o, logic cd, logic d);
        vec_t v;
        v.sel = sel; v.clr = clr; v.en = e; v.ld = ld; v.lv = 4'(lv); v.oc = oc;
        v.chk_comb = cc; v.tc = t; v.co = c; v.cout = cout; v.ovf = o;
        v.chk_done = cd; v.done = d;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic get(input int sel, output int c, output logic t,
                       output logic co, output logic o, output logic d);
        case (sel)
            0:       begin c = int'(c16); t = tc16; co = co16; o = ov16; d = dn16; end
            1:       begin c = int'(c10); t = tc10; co = co10; o = ov10; d = dn10; end
            default: begin c = int'(cos); t = tcos; co = coos; o = ovos; d = dnos; end
        endcase
    endtask

    task automatic drive(input logic c, input logic e, input logic l,
                         input logic [3:0] lv, input logic oc);
        @(negedge clk);
        clear = c; en = e; load = l; load_val = lv; ovf_clr = oc;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int   c;
        logic t, co, o, d;

        clear = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; ovf_clr = 1'b0;
        cclr = 1'b0; cen = 1'b0;

        // ---- reset state ----
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cclr = 1'b1;
        edge_wait();
        for (int s = 0; s < 3; s++) begin
            get(s, c, t, co, o, d);
            chk($sformatf("reset%0d_cout", s), c, 0);
            chk($sformatf("reset%0d_ovf", s), int'(o), 0);
            chk($sformatf("reset%0d_done", s), int'(d), 0);
        end

        // ---- free-run wrap, modulus 16 ----
        for (int k = 1; k <= 17; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
            chk($sformatf("free%0d_tc", k), int'(tc16), int'(((k - 1) % 16) == 15));
            chk($sformatf("free%0d_carry", k), int'(co16), int'(((k - 1) % 16) == 15));
            edge_wait();
            chk($sformatf("free%0d_cout", k), int'(c16), k % 16);
            chk($sformatf("free%0d_ovf", k), int'(ov16), int'(k >= 16));
        end

        // ---- decimal modulus ----
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        edge_wait();
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
            chk($sformatf("dec%0d_tc", k), int'(tc10), int'(((k - 1) % 10) == 9));
            edge_wait();
            chk($sformatf("dec%0d_cout", k), int'(c10), k % 10);
            chk($sformatf("dec%0d_ovf", k), int'(ov10), int'(k >= 10));
        end

        // ---- directed table: load/clamp, sticky races, one-shot ----
        // mod10 starts here at Cout=2, ovf=1
        tbl.push_back(mk(1,0,0,1, 7,0, 1,0,0,  7,1, 0,0));
        tbl.push_back(mk(1,0,0,1,13,0, 1,0,0,  9,1, 0,0));
        tbl.push_back(mk(1,0,1,0, 0,0, 1,1,1,  0,1, 0,0));
        tbl.push_back(mk(1,0,0,1, 9,0, 1,0,0,  9,1, 0,0));
        tbl.push_back(mk(1,0,1,1, 4,0, 1,1,0,  4,1, 0,0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,0,0,  4,1, 0,0));
        // sticky flag races on mod16
        tbl.push_back(mk(0,1,0,0, 0,0, 0,0,0,  0,0, 1,0));
        tbl.push_back(mk(0,0,0,1,15,0, 1,0,0, 15,0, 0,0));
        tbl.push_back(mk(0,0,1,0, 0,0, 1,1,1,  0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 0,1, 1,0,0,  0,0, 0,0));
        tbl.push_back(mk(0,0,0,1,15,0, 1,0,0, 15,0, 0,0));
        tbl.push_back(mk(0,0,1,0, 0,1, 1,1,1,  0,1, 0,0));
        tbl.push_back(mk(0,0,0,1,15,0, 1,0,0, 15,1, 0,0));
        tbl.push_back(mk(0,1,1,0, 0,0, 1,1,0,  0,0, 1,0));
        // one-shot mod16, starting from 0 after the clear above
        tbl.push_back(mk(2,0,0,1,13,0, 1,0,0, 13,0, 1,0));
        tbl.push_back(mk(2,0,1,0, 0,0, 1,0,0, 14,0, 1,0));
        tbl.push_back(mk(2,0,1,0, 0,0, 1,0,0, 15,0, 0,0));
        tbl.push_back(mk(2,0,1,0, 0,0, 1,1,1, 15,0, 1,1));
        tbl.push_back(mk(2,0,1,0, 0,0, 1,1,1, 15,0, 1,1));
        tbl.push_back(mk(2,0,1,0, 0,0, 1,1,1, 15,0, 1,1));
        tbl.push_back(mk(2,0,0,1, 0,0, 1,1,0,  0,0, 1,0));
        tbl.push_back(mk(2,0,0,1,15,0, 1,0,0, 15,0, 1,1));
        tbl.push_back(mk(2,0,0,1, 3,0, 1,1,0,  3,0, 1,0));
        tbl.push_back(mk(2,0,0,1,15,0, 1,0,0, 15,0, 1,1));
        tbl.push_back(mk(2,1,0,0, 0,0, 1,1,0,  0,0, 1,0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].en, tbl[i].ld, tbl[i].lv, tbl[i].oc);
            if (tbl[i].chk_comb) begin
                get(tbl[i].sel, c, t, co, o, d);
                chk($sformatf("vec%0d_tc", i), int'(t), int'(tbl[i].tc));
                chk($sformatf("vec%0d_carry", i), int'(co), int'(tbl[i].co));
            end
            edge_wait();
            get(tbl[i].sel, c, t, co, o, d);
            chk($sformatf("vec%0d_cout", i), c, tbl[i].cout);
            chk($sformatf("vec%0d_ovf", i), int'(o), int'(tbl[i].ovf));
            if (tbl[i].chk_done)
                chk($sformatf("vec%0d_done", i), int'(d), int'(tbl[i].done));
        end

        // ---- two-stage BCD cascade ----
        @(negedge clk);
        cclr = 1'b1; cen = 1'b0;
        edge_wait();
        chk("casc_reset_s0", int'(cs0), 0);
        chk("casc_reset_s1", int'(cs1), 0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            cclr = 1'b0; cen = 1'b1;
            edge_wait();
            chk($sformatf("casc%0d_s0", k), int'(cs0), k % 10);
            chk($sformatf("casc%0d_s1", k), int'(cs1), (k / 10) % 10);
            if (k >= 99)
                chk($sformatf("casc%0d_s1ovf", k), int'(ovs1), int'(k == 100));
        end
        @(negedge clk);
        cen = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
